// File: rtl/embertrail_pkg.sv
// embertrail_pkg: register-file widths and write-packet field positions shared by the writeback path
package embertrail_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 16;
   localparam int REG_COUNT = 32;
   localparam int WB_PKT_W = REG_ADDR_W + REG_DATA_W;
   localparam int REG_FIELD_HI = 20;
   localparam int REG_FIELD_LO = 16;
   typedef logic [WB_PKT_W-1:0] wb_pkt_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   function automatic reg_addr_t pkt_reg(wb_pkt_t p);
      return p[REG_FIELD_HI:REG_FIELD_LO];
   endfunction
endpackage

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: lane handshakes and register-file write ports of the writeback queue
// WB_PENDING_MASK_EN adds oPendingMask
interface writeback_queue_if;
   import embertrail_pkg::*;
   logic iValid1, iValid2;
   wb_pkt_t iResult1, iResult2;
   logic oReady1, oReady2;
   logic oWritePort1, oWritePort2;
   wb_pkt_t oRegWrite1, oRegWrite2;
   logic oIdle;
`ifdef WB_PENDING_MASK_EN
   logic [REG_COUNT-1:0] oPendingMask;
`endif
   modport master (
      output iValid1, iResult1, iValid2, iResult2,
      input oReady1, oReady2, oWritePort1, oRegWrite1, oWritePort2, oRegWrite2, oIdle
`ifdef WB_PENDING_MASK_EN
      , input oPendingMask
`endif
   );
   modport slave (
      input iValid1, iResult1, iValid2, iResult2,
      output oReady1, oReady2, oWritePort1, oRegWrite1, oWritePort2, oRegWrite2, oIdle
`ifdef WB_PENDING_MASK_EN
      , output oPendingMask
`endif
   );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: per-lane writeback FIFO with occupancy count
// WB_PENDING_MASK_EN exposes per-entry valid bits and destination registers
module wb_fifo
   import embertrail_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    push_i,
   input  wb_pkt_t data_i,
   input  logic    pop_i,
   output wb_pkt_t head_o,
   output logic    empty_o,
   output logic    full_o
`ifdef WB_PENDING_MASK_EN
   ,
   output logic [DEPTH-1:0]      valid_o,
   output reg_addr_t [DEPTH-1:0] regs_o
`endif
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0] cnt_q, cnt_d;
   wb_pkt_t mem_q [DEPTH];
   logic do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o = cnt_q == (PW+1)'(DEPTH);
   assign head_o = mem_q[rd_q];
   assign do_push = push_i & !full_o;
   assign do_pop = pop_i & !empty_o;
   always_comb begin
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // storage is deliberately left uncleared by reset
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
`ifdef WB_PENDING_MASK_EN
   // slot i is live when its distance from the read pointer is below the count
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_o[i] = {1'b0, PW'(i) - rd_q} < cnt_q;
         regs_o[i] = pkt_reg(mem_q[i]);
      end
   end
`endif
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers two execution lanes and drains them into the register-file write ports
// WB_PENDING_MASK_EN adds oPendingMask of registers with queued writes
module writeback_queue
   import embertrail_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic iClock,
   input logic iReset,
   writeback_queue_if.slave bus
);
   wb_pkt_t head1, head2;
   reg_addr_t reg1, reg2;
   logic empty1, empty2, full1, full2;
   logic pop1, pop2, wr1, wr2, collide;
`ifdef WB_PENDING_MASK_EN
   logic [DEPTH-1:0] valid1, valid2;
   reg_addr_t [DEPTH-1:0] regs1, regs2;
   logic [REG_COUNT-1:0] pend;
`endif
   wb_fifo #(.DEPTH(DEPTH)) u_lane1 (
      .clk_i(iClock), .rst_i(iReset), .push_i(bus.iValid1 & bus.oReady1), .data_i(bus.iResult1),
      .pop_i(pop1), .head_o(head1), .empty_o(empty1), .full_o(full1)
`ifdef WB_PENDING_MASK_EN
      , .valid_o(valid1), .regs_o(regs1)
`endif
   );
   wb_fifo #(.DEPTH(DEPTH)) u_lane2 (
      .clk_i(iClock), .rst_i(iReset), .push_i(bus.iValid2 & bus.oReady2), .data_i(bus.iResult2),
      .pop_i(pop2), .head_o(head2), .empty_o(empty2), .full_o(full2)
`ifdef WB_PENDING_MASK_EN
      , .valid_o(valid2), .regs_o(regs2)
`endif
   );
   assign reg1 = pkt_reg(head1);
   assign reg2 = pkt_reg(head2);
   // same-register collision: lane 1 goes first so lane 2's value lands last
   always_comb begin
      collide = !empty1 & !empty2 & (reg1 != '0) & (reg1 == reg2);
      pop1 = !empty1 & !iReset;
      pop2 = !empty2 & !iReset & !collide;
      wr1 = pop1 & (reg1 != '0);
      wr2 = pop2 & (reg2 != '0);
   end
   assign bus.oReady1 = !full1 & !iReset;
   assign bus.oReady2 = !full2 & !iReset;
   assign bus.oWritePort1 = wr1;
   assign bus.oWritePort2 = wr2;
   assign bus.oRegWrite1 = wr1 ? head1 : '0;
   assign bus.oRegWrite2 = wr2 ? head2 : '0;
   assign bus.oIdle = (empty1 & empty2) | iReset;
`ifdef WB_PENDING_MASK_EN
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid1[i]) pend[regs1[i]] = 1'b1;
         if (valid2[i]) pend[regs2[i]] = 1'b1;
      end
      pend[0] = 1'b0;
   end
   assign bus.oPendingMask = iReset ? '0 : pend;
`endif
endmodule
